reset_seq: RTL and testbench

Parametrised, multi-channel reset sequencer. Generalises the fixed power-on reset counter in our board tops into a reusable block. It holds all downstream reset lines asserted for a programmable time after power-up, a synchronous reset, an external request or a watchdog timeout. It then releases them one channel at a time with a programmable stagger, and reports the cause of the last reset. It sits between the board clock/button pins and the CPU, ROM and peripheral instances in each board top.

---
 rtl/reset_seq.sv | 147 ++++++++++++++
 tb/tb_reset_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: programmable hold, staggered per-channel release,
// synchronised external request, watchdog and last-reset-cause reporting.
module reset_seq #(
    parameter int NUM_OUT     = 2,
    parameter int TIMER_BIT   = 22,
    parameter int STAGGER_BIT = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WDT_BIT     = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_in,
    input  logic               wdt_enable,
    input  logic               wdt_kick,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               ready,
    output logic [1:0]         cause
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int CNT_W = max3(TIMER_BIT, WDT_BIT, STAGGER_BIT) + 1;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_RST = 2'd1;
    localparam logic [1:0] CAUSE_REQ = 2'd2;
    localparam logic [1:0] CAUSE_WDT = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    // Declaration initial values give a working power-up with reset tied low.
    state_t                 r_state   = S_HOLD;
    logic [CNT_W-1:0]       r_cnt     = '0;
    logic [NUM_OUT-1:0]     r_rst_out = '1;
    logic                   r_ready   = 1'b0;
    logic [1:0]             r_cause   = CAUSE_POR;
    logic [SYNC_STAGES-1:0] r_sync    = '0;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NUM_OUT-1:0] w_rst_next;
    logic [NUM_OUT-1:0] w_rst_shift;
    logic               w_ready_next;
    logic [1:0]         w_cause_next;
    logic               w_req_sync;

    assign w_req_sync  = r_sync[SYNC_STAGES-1];
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    // Channels release from bit 0 upward, so shifting in a zero frees the next one.
    assign w_rst_shift = r_rst_out << 1;

    always_ff @(posedge clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rst_next   = r_rst_out;
        w_ready_next = 1'b0;
        w_cause_next = r_cause;

        if (w_req_sync) begin
            w_state_next = S_HOLD;
            w_cnt_next   = '0;
            w_rst_next   = '1;
            w_cause_next = CAUSE_REQ;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt[TIMER_BIT]) begin
                        w_state_next = S_RELEASE;
                        w_cnt_next   = '0;
                        w_rst_next   = w_rst_shift;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                S_RELEASE: begin
                    // Empty mask only happens for a single channel released from HOLD.
                    if (r_rst_out == '0) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc[STAGGER_BIT]) begin
                        w_cnt_next = '0;
                        w_rst_next = w_rst_shift;
                        if (w_rst_shift == '0) begin
                            w_state_next = S_RUN;
                        end
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                S_RUN: begin
                    w_ready_next = 1'b1;
                    // A kick on the firing cycle takes precedence over the timeout.
                    if (r_cnt[WDT_BIT] && !wdt_kick) begin
                        w_state_next = S_HOLD;
                        w_cnt_next   = '0;
                        w_rst_next   = '1;
                        w_ready_next = 1'b0;
                        w_cause_next = CAUSE_WDT;
                    end else if (wdt_kick || !wdt_enable) begin
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = '0;
                    w_rst_next   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= CAUSE_RST;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rst_out <= w_rst_next;
            r_ready   <= w_ready_next;
            r_cause   <= w_cause_next;
        end
    end

    assign reset_out = r_rst_out;
    assign ready     = r_ready;
    assign cause     = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: a timestamp-based model predicts every output
// change; a monitor pops predictions whenever the DUT outputs change.
module tb_reset_seq;

    localparam int N      = 3;
    localparam int TB     = 4;
    localparam int SB     = 2;
    localparam int SS     = 2;
    localparam int WB     = 5;
    localparam int HOLD_E = (1 << TB) + 1;
    localparam int STEP   = 1 << SB;
    localparam int WDT_E  = (1 << WB) + 1;
    localparam logic [5:0] POWER_UP = 6'b111_0_00;

    logic         clk        = 1'b0;
    logic         reset      = 1'b0;
    logic         req_in     = 1'b0;
    logic         wdt_enable = 1'b0;
    logic         wdt_kick   = 1'b0;
    logic [N-1:0] reset_out;
    logic         ready;
    logic [1:0]   cause;

    reset_seq #(
        .NUM_OUT    (N),
        .TIMER_BIT  (TB),
        .STAGGER_BIT(SB),
        .SYNC_STAGES(SS),
        .WDT_BIT    (WB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .wdt_enable(wdt_enable),
        .wdt_kick  (wdt_kick),
        .reset_out (reset_out),
        .ready     (ready),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [5:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   done    = 1'b0;

    // Outputs after edge e, given the edge of the last reset event and its cause.
    function automatic logic [5:0] model_out(input int e, input int anc, input logic [1:0] c);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (e < anc + HOLD_E + k * STEP);
        return {r, (e >= anc + HOLD_E + (N - 1) * STEP + 1), c};
    endfunction

    int         m_edge   = 0;
    int         m_anchor = 0;
    int         m_lastclr = 0;
    logic [1:0] m_cause  = 2'd0;
    logic [5:0] m_prev   = POWER_UP;
    logic       req_hist[$];

    always @(posedge clk) begin : model
        logic       rs;
        int         run_entry;
        logic [5:0] cur;
        exp_t       item;
        m_edge++;
        rs = (m_edge > SS) ? req_hist[m_edge - SS - 1] : 1'b0;
        req_hist.push_back(req_in);
        run_entry = m_anchor + HOLD_E + (N - 1) * STEP;
        if (reset) begin
            m_anchor = m_edge;
            m_cause  = 2'd1;
        end else if (rs) begin
            m_anchor = m_edge;
            m_cause  = 2'd2;
        end else if (m_edge == run_entry) begin
            m_lastclr = m_edge;
        end else if (m_edge > run_entry) begin
            if (m_edge - m_lastclr == WDT_E && !wdt_kick) begin
                m_anchor = m_edge;
                m_cause  = 2'd3;
            end else if (wdt_kick || !wdt_enable) begin
                m_lastclr = m_edge;
            end
        end
        cur = model_out(m_edge, m_anchor, m_cause);
        if (cur != m_prev) begin
            item.at_edge = m_edge;
            item.val     = cur;
            exp_q.push_back(item);
        end
        m_prev = cur;
    end

    initial begin : monitor
        logic [5:0] obs;
        logic [5:0] last;
        exp_t       e;
        int         edge_n;
        #1;
        obs = {reset_out, ready, cause};
        n_total++;
        if (obs === POWER_UP) n_pass++;
        else $display("FAIL power_up_state: got %b required %b", obs, POWER_UP);
        last   = POWER_UP;
        edge_n = 0;
        while (!done) begin
            @(negedge clk);
            edge_n++;
            obs = {reset_out, ready, cause};
            if (obs !== last) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL output_change: got %b at edge %0d required no change", obs, edge_n);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at_edge == edge_n && e.val === obs) n_pass++;
                    else $display("FAIL output_change: got %b at edge %0d required %b at edge %0d",
                                  obs, edge_n, e.val, e.at_edge);
                end
                last = obs;
            end
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_changes: got %0d unobserved changes (next %b at edge %0d) required 0",
                      exp_q.size(), exp_q[0].val, exp_q[0].at_edge);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        int total;
        int gap;
        // Power-up with reset tied low.
        tick(40);
        // Three-cycle reset pulse while running.
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(40);
        // Request arriving after channel 0 has been released.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(19);
        req_in = 1'b1;
        tick(10);
        req_in = 1'b0;
        tick(40);
        // Regular kicks, then starve the watchdog.
        wdt_enable = 1'b1;
        total = 0;
        while (total < 200) begin
            gap = int'($urandom_range(15, 25));
            tick(gap - 1);
            wdt_kick = 1'b1;
            tick();
            wdt_kick = 1'b0;
            total += gap;
        end
        tick(80);
        wdt_enable = 1'b0;
        // Kick landing exactly on the firing cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdt_enable = 1'b1;
        tick(27);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        tick(32);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        tick(20);
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        // Watchdog disabled for a long stretch, then re-enabled without kicks.
        wdt_enable = 1'b0;
        tick(100);
        wdt_enable = 1'b1;
        tick(40);
        wdt_enable = 1'b0;
        tick(30);
        // Reset and request together.
        reset  = 1'b1;
        req_in = 1'b1;
        tick(5);
        req_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(30);
        // Reset on the same edge as the second watchdog firing.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdt_enable = 1'b1;
        tick(115);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wdt_enable = 1'b0;
        tick(30);
        // Randomised mix of all inputs.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) req_in = ~req_in;
            if ($urandom_range(0, 49) == 0) wdt_enable = ~wdt_enable;
            wdt_kick = ($urandom_range(0, 29) == 0);
            tick();
        end
        reset      = 1'b0;
        req_in     = 1'b0;
        wdt_enable = 1'b0;
        wdt_kick   = 1'b0;
        tick(40);
        done = 1'b1;
    end

endmodule
